// File: rtl/ppu_pkg.sv
// Shared PPU definitions for the sprite fetch sequencer: FSM states, slot count,
// attribute bit positions and secondary-OAM byte offsets.
package ppu_pkg;

    localparam int SLOTS = 8;

    localparam int ATTR_VFLIP = 7;
    localparam int ATTR_HFLIP = 6;
    localparam int ATTR_PRIO  = 5;

    localparam logic [1:0] OAM_Y    = 2'd0;
    localparam logic [1:0] OAM_TILE = 2'd1;
    localparam logic [1:0] OAM_ATTR = 2'd2;
    localparam logic [1:0] OAM_X    = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A0,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_A4,
        ST_LO,
        ST_HI,
        ST_CLR0,
        ST_CLR1,
        ST_NEXT
    } fetch_state_t;

    function automatic logic [3:0] clamp_count(input logic [3:0] cnt);
        return (cnt > 4'd8) ? 4'd8 : cnt;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Pattern-table address for one sprite row: applies vertical flip and the
// 8x8 / 8x16 table layouts.
module sprite_addr_gen (
    input  logic [7:0]  y,
    input  logic [7:0]  tile,
    input  logic [7:0]  line,
    input  logic        vflip,
    input  logic        sprite_size,
    input  logic        sprite_pt_sel,
    input  logic        plane,
    output logic [13:0] addr
);

    logic [7:0] diff;
    logic [3:0] row;
    logic       unused;

    assign unused = ^diff[7:4];

    always_comb begin
        diff = line - y;
        row  = diff[3:0];
        if (vflip) begin
            row = row ^ (sprite_size ? 4'hF : 4'h7);
        end
        // 8x16 sprites pick their table from tile bit 0 and use row bit 3 to select the lower tile
        if (sprite_size) begin
            addr = {1'b0, tile[0], tile[7:1], row[3], plane, row[2:0]};
        end else begin
            addr = {1'b0, sprite_pt_sel, tile, plane, row[2:0]};
        end
    end

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Horizontal-blank sprite fetch sequencer: walks the eight secondary-OAM slots,
// fetches both pattern planes over the VRAM port and loads the sprite shifters.
module sprite_fetch_ctrl
    import ppu_pkg::*;
#(
    parameter int SLOTS = ppu_pkg::SLOTS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_start,
    input  logic [8:0]         scanline,
    input  logic               sprite_size,
    input  logic               sprite_pt_sel,
    input  logic [3:0]         sprite_count,
    output logic [4:0]         soam_addr,
    input  logic [7:0]         soam_data,
    output logic               vram_req,
    output logic [13:0]        vram_addr,
    input  logic               vram_ack,
    input  logic [7:0]         vram_data,
    output logic [SLOTS-1:0]   pattern0_ld,
    output logic [SLOTS-1:0]   pattern1_ld,
    output logic [7:0]         pattern_out,
    output logic [SLOTS-1:0]   slot_valid,
    output logic [4*SLOTS-1:0] slot_attr,
    output logic [8*SLOTS-1:0] slot_x,
    output logic               busy,
    output logic               done
);

    fetch_state_t state;
    logic [2:0]   s;
    logic [2:0]   s_nx;
    logic [3:0]   count;
    logic [3:0]   count_eff;
    logic         start_slot;
    logic         slot_has;
    logic [7:0]   y;
    logic [7:0]   tile;
    logic [7:0]   x;
    logic         vflip;
    logic [3:0]   attr;
    logic [13:0]  addr;
    logic         unused;

    assign unused = scanline[8];

    // Slot entry is shared by IDLE (first slot) and NEXT (following slots)
    assign s_nx       = (state == ST_IDLE) ? 3'd0 : s + 3'd1;
    assign count_eff  = (state == ST_IDLE) ? clamp_count(sprite_count) : count;
    assign start_slot = ((state == ST_IDLE) && fetch_start) || ((state == ST_NEXT) && (s != 3'd7));
    assign slot_has   = ({1'b0, s_nx} < count_eff);

    sprite_addr_gen u_addr_gen (
        .y             (y),
        .tile          (tile),
        .line          (scanline[7:0]),
        .vflip         (vflip),
        .sprite_size   (sprite_size),
        .sprite_pt_sel (sprite_pt_sel),
        .plane         (state == ST_LO),
        .addr          (addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            s           <= '0;
            count       <= '0;
            soam_addr   <= '0;
            vram_req    <= 1'b0;
            vram_addr   <= '0;
            pattern0_ld <= '0;
            pattern1_ld <= '0;
            pattern_out <= '0;
            slot_valid  <= '0;
            slot_attr   <= '0;
            slot_x      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pattern0_ld <= '0;
            pattern1_ld <= '0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        count <= count_eff;
                        busy  <= 1'b1;
                    end
                end
                ST_A0: begin
                    soam_addr <= {s, OAM_TILE};
                    state     <= ST_A1;
                end
                ST_A1: begin
                    y         <= soam_data;
                    soam_addr <= {s, OAM_ATTR};
                    state     <= ST_A2;
                end
                ST_A2: begin
                    tile      <= soam_data;
                    soam_addr <= {s, OAM_X};
                    state     <= ST_A3;
                end
                ST_A3: begin
                    vflip <= soam_data[ATTR_VFLIP];
                    attr  <= {soam_data[ATTR_HFLIP], soam_data[ATTR_PRIO], soam_data[1:0]};
                    state <= ST_A4;
                end
                ST_A4: begin
                    x         <= soam_data;
                    vram_req  <= 1'b1;
                    vram_addr <= addr;
                    state     <= ST_LO;
                end
                ST_LO: begin
                    if (vram_ack) begin
                        pattern_out <= vram_data;
                        pattern0_ld <= SLOTS'(1) << s;
                        vram_addr   <= addr;
                        state       <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (vram_ack) begin
                        pattern_out        <= vram_data;
                        vram_req           <= 1'b0;
                        pattern1_ld        <= SLOTS'(1) << s;
                        slot_attr[4*s +: 4] <= attr;
                        slot_x[8*s +: 8]   <= x;
                        slot_valid[s]      <= 1'b1;
                        done               <= (s == 3'd7);
                        state              <= ST_NEXT;
                    end
                end
                ST_CLR0: begin
                    pattern1_ld <= SLOTS'(1) << s;
                    state       <= ST_CLR1;
                end
                ST_CLR1: begin
                    slot_valid[s] <= 1'b0;
                    done          <= (s == 3'd7);
                    state         <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (s == 3'd7) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (start_slot) begin
                s <= s_nx;
                if (slot_has) begin
                    soam_addr <= {s_nx, OAM_Y};
                    state     <= ST_A0;
                end else begin
                    pattern_out <= '0;
                    pattern0_ld <= SLOTS'(1) << s_nx;
                    state       <= ST_CLR0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Bench for sprite_fetch_ctrl: secondary-OAM and VRAM responders, a line-level
// reference model, table vectors from the test plan and randomized lines.
module tb_sprite_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [8:0]  scanline;
    logic        sprite_size;
    logic        sprite_pt_sel;
    logic [3:0]  sprite_count;
    logic [4:0]  soam_addr;
    logic [7:0]  soam_data;
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_data;
    logic [7:0]  pattern0_ld;
    logic [7:0]  pattern1_ld;
    logic [7:0]  pattern_out;
    logic [7:0]  slot_valid;
    logic [31:0] slot_attr;
    logic [63:0] slot_x;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sprite_fetch_ctrl #(.SLOTS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_start   (fetch_start),
        .scanline      (scanline),
        .sprite_size   (sprite_size),
        .sprite_pt_sel (sprite_pt_sel),
        .sprite_count  (sprite_count),
        .soam_addr     (soam_addr),
        .soam_data     (soam_data),
        .vram_req      (vram_req),
        .vram_addr     (vram_addr),
        .vram_ack      (vram_ack),
        .vram_data     (vram_data),
        .pattern0_ld   (pattern0_ld),
        .pattern1_ld   (pattern1_ld),
        .pattern_out   (pattern_out),
        .slot_valid    (slot_valid),
        .slot_attr     (slot_attr),
        .slot_x        (slot_x),
        .busy          (busy),
        .done          (done)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] soam_mem [32];
    int         waits [16];
    int         ridx;
    int         wcnt;
    logic [7:0] salt;
    logic       noise;

    int         exp_req [$];
    logic [7:0] exp_p0 [8];
    logic [7:0] exp_p1 [8];
    logic [7:0] exp_x [8];
    logic [3:0] exp_attr [8];
    logic [7:0] exp_valid;
    int         exp_total;
    int         exp_reqcyc;
    int         got_req [$];
    int         got_done;

    typedef struct {
        int         count;
        logic       size;
        logic       pt;
        int         line;
        int         w;
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
        int         nreq;
        int         lo;
        int         hi;
        int         done_c;
        logic [3:0] attr4;
        logic [7:0] valid;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [7:0] vdata(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ salt;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Secondary OAM: synchronous RAM with one cycle of read latency
    initial begin
        logic [4:0] a;
        soam_data = 8'h00;
        forever begin
            @(posedge clk);
            a = soam_addr;
            #1 soam_data = soam_mem[a];
        end
    end

    // VRAM: acks each request after waits[n] cycles; optional stray acks while idle
    initial begin
        vram_ack  = 1'b0;
        vram_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (vram_req) begin
                if (wcnt >= waits[ridx & 15]) begin
                    vram_ack  = 1'b1;
                    vram_data = vdata(vram_addr);
                    wcnt      = 0;
                    ridx++;
                end else begin
                    vram_ack  = 1'b0;
                    vram_data = 8'($urandom);
                    wcnt++;
                end
            end else begin
                vram_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                vram_data = 8'($urandom);
                wcnt      = 0;
            end
        end
    end

    // Line-level expectations computed straight from the fetch rules
    task automatic model();
        int n;
        n = (int'(sprite_count) > 8) ? 8 : int'(sprite_count);
        exp_req.delete();
        exp_total  = 0;
        exp_reqcyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                int yv = int'(soam_mem[4*i]);
                int t  = int'(soam_mem[4*i+1]);
                int a  = int'(soam_mem[4*i+2]);
                int row;
                int lo;
                row = (int'(scanline[7:0]) - yv) & 15;
                if (a >= 128) row = sprite_size ? (15 - row) : (row ^ 7);
                if (sprite_size) lo = (t % 2) * 4096 + (t / 2) * 32 + (row / 8) * 16 + row % 8;
                else lo = int'(sprite_pt_sel) * 4096 + t * 16 + row % 8;
                exp_req.push_back(lo);
                exp_req.push_back(lo + 8);
                exp_p0[i] = vdata(14'(lo));
                exp_p1[i] = vdata(14'(lo + 8));
                exp_total  += 8 + waits[2*i] + waits[2*i+1];
                exp_reqcyc += 2 + waits[2*i] + waits[2*i+1];
                exp_attr[i]  = 4'(((a / 64) % 2) * 8 + ((a / 32) % 2) * 4 + a % 4);
                exp_x[i]     = soam_mem[4*i+3];
                exp_valid[i] = 1'b1;
            end else begin
                exp_p0[i] = 8'h00;
                exp_p1[i] = 8'h00;
                exp_total += 3;
                exp_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input int extra_start);
        int         cyc = 0;
        int         ndone = 0;
        int         nbusy = 0;
        int         unstable = 0;
        int         reqcyc = 0;
        int         n0 = 0;
        int         n1 = 0;
        logic       prev_req = 1'b0;
        logic       prev_ack = 1'b0;
        logic [13:0] prev_addr = '0;
        int         c0 [8];
        int         c1 [8];
        logic [7:0] l0 [8];
        logic [7:0] l1 [8];
        logic [7:0] d0 [8];
        logic [7:0] d1 [8];
        logic [31:0] ea;
        logic [63:0] ex;
        for (int i = 0; i < 8; i++) begin
            c0[i] = 0; c1[i] = 0; l0[i] = 0; l1[i] = 0; d0[i] = 0; d1[i] = 0;
        end
        model();
        got_req.delete();
        got_done = -1;
        ridx = 0;
        wcnt = 0;
        @(negedge clk);
        fetch_start = 1'b1;
        while (cyc < 400 && !(got_done >= 0 && cyc >= got_done + 2)) begin
            @(negedge clk);
            cyc++;
            fetch_start = (cyc == extra_start);
            if (vram_req) begin
                reqcyc++;
                if (!prev_req || prev_ack) got_req.push_back(int'(vram_addr));
                else if (vram_addr != prev_addr) unstable++;
            end
            prev_req  = vram_req;
            prev_ack  = vram_ack;
            prev_addr = vram_addr;
            if (pattern0_ld != 0) begin
                if (n0 < 8) begin l0[n0] = pattern0_ld; d0[n0] = pattern_out; c0[n0] = cyc; end
                n0++;
            end
            if (pattern1_ld != 0) begin
                if (n1 < 8) begin l1[n1] = pattern1_ld; d1[n1] = pattern_out; c1[n1] = cyc; end
                n1++;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (got_done < 0) got_done = cyc;
            end
        end
        fetch_start = 1'b0;
        chk("done_cycle", got_done, exp_total);
        chk("done_pulses", ndone, 1);
        chk("busy_cycles", nbusy, exp_total);
        chk("req_count", got_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
            chk("req_addr", got_req[i], exp_req[i]);
        chk("req_stable", unstable, 0);
        chk("req_cycles", reqcyc, exp_reqcyc);
        chk("p0_count", n0, 8);
        chk("p1_count", n1, 8);
        for (int i = 0; i < 8; i++) begin
            chk("p0_load", {l0[i], d0[i]}, {8'(1 << i), exp_p0[i]});
            chk("p1_load", {l1[i], d1[i]}, {8'(1 << i), exp_p1[i]});
            chk("lo_before_hi", c0[i] < c1[i], 1);
        end
        for (int i = 0; i < 8; i++) begin
            ea[4*i +: 4] = exp_attr[i];
            ex[8*i +: 8] = exp_x[i];
        end
        chk("slot_valid", slot_valid, exp_valid);
        chk("slot_attr", slot_attr, ea);
        chk("slot_x", slot_x, ex);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {soam_addr, vram_req, vram_addr, pattern0_ld, pattern1_ld, busy, done}, 0);
        chk({tag, "_data"}, {pattern_out, slot_valid, slot_attr}, 0);
        chk({tag, "_x"}, slot_x, 0);
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 8; i++) begin
            exp_x[i]    = 8'h00;
            exp_attr[i] = 4'h0;
        end
        exp_valid = 8'h00;
    endtask

    initial begin
        int quiet;
        rst = 1'b1; fetch_start = 1'b0; scanline = '0; sprite_size = 1'b0;
        sprite_pt_sel = 1'b0; sprite_count = '0; noise = 1'b0; salt = 8'h5A;
        ridx = 0; wcnt = 0;
        for (int i = 0; i < 16; i++) waits[i] = 0;
        for (int i = 0; i < 32; i++) soam_mem[i] = 8'h00;
        clear_shadow();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // count, size, pt, line, wait, Y, tile, attr, X | nreq, lo, hi, done, attr4, valid
        tbl[0] = '{1,  1'b0, 1'b1, 12, 0, 8'd10,   8'h42, 8'h41, 8'h80, 2,  'h1422, 'h142A, 29, 4'b1001, 8'h01};
        tbl[1] = '{1,  1'b1, 1'b0, 25, 0, 8'd20,   8'h43, 8'h80, 8'h10, 2,  'h1432, 'h143A, 29, 4'b0000, 8'h01};
        tbl[2] = '{1,  1'b0, 1'b1, 12, 3, 8'd10,   8'h42, 8'h41, 8'h80, 2,  'h1422, 'h142A, 35, 4'b1001, 8'h01};
        // empty line keeps slot 0 attribute from the previous row
        tbl[3] = '{0,  1'b0, 1'b1, 12, 0, 8'd10,   8'h42, 8'h41, 8'h80, 0,  0,       0,       24, 4'b1001, 8'h00};
        tbl[4] = '{12, 1'b0, 1'b0, 53, 0, 8'h30,   8'h10, 8'h23, 8'h44, 16, 'h0105, 'h010D, 64, 4'b0111, 8'hFF};

        for (int t = 0; t < 5; t++) begin
            sprite_count  = 4'(tbl[t].count);
            sprite_size   = tbl[t].size;
            sprite_pt_sel = tbl[t].pt;
            scanline      = 9'(tbl[t].line);
            for (int i = 0; i < 32; i++) soam_mem[i] = 8'($urandom);
            soam_mem[0] = tbl[t].y; soam_mem[1] = tbl[t].tile;
            soam_mem[2] = tbl[t].attr; soam_mem[3] = tbl[t].x;
            for (int i = 0; i < 16; i++) waits[i] = tbl[t].w;
            salt = 8'($urandom);
            run_frame(0);
            chk("tbl_nreq", got_req.size(), tbl[t].nreq);
            if (tbl[t].nreq > 0) begin
                chk("tbl_lo", got_req.size() > 0 ? got_req[0] : -1, tbl[t].lo);
                chk("tbl_hi", got_req.size() > 1 ? got_req[1] : -1, tbl[t].hi);
            end
            chk("tbl_done", got_done, tbl[t].done_c);
            chk("tbl_attr0", slot_attr[3:0], tbl[t].attr4);
            chk("tbl_valid", slot_valid, tbl[t].valid);
        end

        // fetch_start while busy must not restart the line
        sprite_count = 4'd3;
        for (int i = 0; i < 16; i++) waits[i] = int'($urandom_range(0, 3));
        run_frame(10);

        // reset in the middle of a full line
        sprite_count = 4'd8;
        for (int i = 0; i < 16; i++) waits[i] = 0;
        ridx = 0; wcnt = 0;
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        clear_shadow();
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (pattern0_ld != 0 || pattern1_ld != 0 || vram_req || busy || done) quiet++;
        end
        chk("midrst_quiet", quiet, 0);

        noise = 1'b1;
        for (int f = 0; f < 30; f++) begin
            sprite_count  = 4'($urandom_range(0, 15));
            sprite_size   = 1'($urandom_range(0, 1));
            sprite_pt_sel = 1'($urandom_range(0, 1));
            scanline      = 9'($urandom);
            for (int i = 0; i < 32; i++) soam_mem[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) waits[i] = int'($urandom_range(0, 3));
            salt = 8'($urandom);
            run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_ctrl.md
# sprite_fetch_ctrl

Sequencer for the PPU's eight per-line sprite shifters (`sprite_buffer` slots). It runs during the horizontal-blank sprite-fetch window, after sprite evaluation has filled secondary OAM for the next scanline. For each slot it:

- reads the 4-byte secondary-OAM entry;
- computes the pattern-table addresses;
- fetches the low and high bit-plane bytes over a request/acknowledge VRAM port;
- drives the slot's load strobes, X position, attribute and valid latches.

## Interface
Parameters:
- `SLOTS`, 8: number of sprite shifter slots. Slot index width is 3 bits; only 8 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_start` in 1: single-cycle pulse that opens the fetch window.
- `scanline` in 9: number of the line being prepared.
- `sprite_size` in 1: sprite height; 0 = 8x8, 1 = 8x16.
- `sprite_pt_sel` in 1: pattern table used for 8x8 sprites.
- `sprite_count` in 4: number of valid secondary-OAM entries; values above 8 are clamped to 8.
- `soam_addr` out 5: secondary-OAM byte address. The RAM is synchronous with 1-cycle read latency.
- `soam_data` in 8: secondary-OAM read data.
- `vram_req` out 1: VRAM read request.
- `vram_addr` out 14: VRAM read address.
- `vram_ack` in 1: VRAM acknowledge.
- `vram_data` in 8: VRAM read data, valid in the `vram_ack` cycle.
- `pattern0_ld` out `SLOTS`: one-hot low-plane load strobe per slot.
- `pattern1_ld` out `SLOTS`: one-hot high-plane load strobe per slot.
- `pattern_out` out 8: pattern byte shared by all slots.
- `slot_valid` out `SLOTS`: per-slot valid flag.
- `slot_attr` out 4*`SLOTS`: per-slot attribute, packed as {hflip, priority, palette[1:0]}.
- `slot_x` out 8*`SLOTS`: per-slot X position.
- `busy` out 1: high from the cycle after `fetch_start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at the end of the window.

## Operation
- **FSM states:** IDLE, A0–A4, LO, HI, CLR0, CLR1, NEXT. The slot counter `s` is 3 bits.
- **IDLE:**
  - When `fetch_start` is seen: `s` = 0.
  - Go to A0 if `s` < clamped `sprite_count`, otherwise go to CLR0.
  - `fetch_start` while not in IDLE is ignored.
- **A0–A3:** `soam_addr` = {s, k} for state Ak.
- **A1–A4:** each captures `soam_data` as Y, tile, attr and X respectively.
- **Row computation:**
  - row = (`scanline`[7:0] − Y), 8-bit wrap; the low 4 bits are used.
  - If attr[7] (vflip) is set: row ^= 7 for 8x8, row ^= 15 for 8x16.
- **Addressing:**
  - 8x8: `vram_addr` = {0, `sprite_pt_sel`, tile, plane, row[2:0]}.
  - 8x16: `vram_addr` = {0, tile[0], tile[7:1], row[3], plane, row[2:0]}.
  - plane = 0 in LO, 1 in HI.
- **LO / HI:**
  - `vram_req` = 1 with a stable address until `vram_ack`.
  - On ack, `pattern_out` <= `vram_data` and the state advances.
- **Load strobes:**
  - `pattern0_ld[s]` pulses in the first HI cycle.
  - `pattern1_ld[s]` pulses in the NEXT cycle.
  - In that same NEXT cycle, `slot_attr[s]` <= {attr[6], attr[5], attr[1:0]}, `slot_x[s]` <= X, `slot_valid[s]` <= 1.
  - Low plane is always loaded strictly before high plane, because the shifter copies the low byte on the high-plane load.
- **Empty slots (CLR0 / CLR1):**
  - No VRAM request.
  - CLR0: `pattern_out` = 0 and `pattern0_ld[s]`.
  - CLR1: `pattern1_ld[s]`.
  - NEXT: `slot_valid[s]` = 0; `slot_x` and `slot_attr` are unchanged.
- **NEXT:**
  - If `s` = 7: `done` = 1, go to IDLE.
  - Otherwise `s` += 1 and go to A0 or CLR0.
- **Reset values:**
  - All strobes, `vram_req`, `busy` and `done` = 0.
  - `pattern_out`, `slot_x`, `slot_attr`, `slot_valid`, `soam_addr` and `vram_addr` = 0.
  - FSM returns to IDLE. Reset mid-fetch abandons the request; no further strobes are issued.

## Timing
- `fetch_start` is sampled in cycle 0; A0 or CLR0 is entered in cycle 1.
- **Valid slot with zero wait:** 8 cycles (A0–A4, LO, HI, NEXT).
- **Empty slot:** 3 cycles.
- Each VRAM wait cycle adds 1 cycle.
- `done` arrives at cycle 64 for 8 valid zero-wait slots and at cycle 24 for `sprite_count` = 0.
- `vram_req` falls in the cycle after ack. No request is ever issued back-to-back without a state change.
- `vram_ack` while `vram_req` = 0 is ignored.

## Structure
- Shared package `ppu_pkg`: FSM state enum, `SLOTS`, `ATTR_HFLIP`/`ATTR_PRIO` bit indices, OAM byte offsets.
- Sub-module `sprite_addr_gen` (combinational): computes row, flip and 14-bit address from Y, tile, vflip, `sprite_size`, `sprite_pt_sel`, `scanline` and plane.

## Test plan
- **8x8 with hflip:** `sprite_count` = 1; entry Y = 10, tile = 0x42, attr = 0x41, X = 0x80; `scanline` = 12, `sprite_pt_sel` = 1, zero-wait ack.
  - Requests at 0x1422 then 0x142A.
  - `slot_attr[0]` = 4'b1001, `slot_x[0]` = 0x80, `slot_valid[0]` = 1.
  - Slots 1–7 get zero loads and valid = 0; `done` at cycle 29.
- **8x16 with vflip:** `sprite_size` = 1; Y = 20, tile = 0x43, attr = 0x80; `scanline` = 25.
  - Addresses 0x1432 and 0x143A.
- **Wait states:** ack delayed 3 cycles.
  - `vram_req` and `vram_addr` stable for 4 cycles.
  - Exactly one `pattern0_ld` pulse, carrying the acked data.
- **Empty line:** `sprite_count` = 0.
  - No `vram_req`; 8 CLR pairs with `pattern_out` = 0.
  - `done` at cycle 24; all `slot_valid` = 0.
- **Full line:** `sprite_count` = 12 (clamped to 8), zero wait.
  - 16 requests, `done` at cycle 64.
  - Strobes are one-hot per slot, and `pattern0_ld` precedes `pattern1_ld` in every slot.
- **Reset and restart:** `rst` at cycle 20 of a fetch gives IDLE and all outputs 0 next cycle. `fetch_start` during `busy` causes no restart.
